div_request_sequencer: RTL and testbench

//  Upstream front end of the DivisionUnit. Accepts operand pairs on a valid/ready stream,

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_op_fifo.sv | 80 ++++++++
 rtl/div_request_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_div_request_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider request sequencer.
// Holds the sequencer state encoding, error bit indices and a clog2 helper
// for sizing pointers and timers from parameters.
package div_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_ISSUE   = 2'd1,
    SEQ_RELEASE = 2'd2,
    SEQ_OUTPUT  = 2'd3
  } seq_state_e;

  localparam int unsigned ERR_W       = 2;
  localparam int unsigned ERR_DBZ     = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  // Ceiling log2 for parameter-derived widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result = result + 32'd1;
    return result;
  endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Operand-pair FIFO feeding the divider request sequencer.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   push_i/push_data_i  write request and data (accepted when ready_o=1)
//   pop_i          remove head entry (ignored when empty)
//   head_o         current head entry
//   empty_o        registered empty flag
//   empty_next_o   empty flag as it will be after this edge
//   ready_o        registered !full; no pop-bypass
module div_op_fifo
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  empty_next_o,
  output logic                  ready_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, empty_q;
  logic                  do_push, do_pop;

  assign do_push = push_i & ready_q;
  assign do_pop  = pop_i & ~empty_q;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= (cnt_d != CNT_W'(DEPTH));
      empty_q  <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign empty_o      = empty_q;
  assign empty_next_o = (cnt_d == '0);
  assign ready_o      = ready_q;

endmodule

// File: rtl/div_request_sequencer.sv
// Front end of the division unit: buffers operand pairs, issues them one at a
// time over the divider enable/valid handshake, and presents quot/mod/err on a
// valid/ready result stream. Divide-by-zero bypasses the divider; hung
// handshake phases are aborted after TIMEOUT_CYCLES.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_left/in_right      operand stream
//   div_enable/div_left_op/div_right_op     request to divider
//   div_valid/div_quot/div_mod              divider response
//   out_valid/out_ready/out_quot/out_mod/out_err  result stream
//   busy                         sequencer active or FIFO non-empty
module div_request_sequencer
  import div_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_left,
  input  logic [WORD_WIDTH-1:0] in_right,
  output logic                  div_enable,
  output logic [WORD_WIDTH-1:0] div_left_op,
  output logic [WORD_WIDTH-1:0] div_right_op,
  input  logic                  div_valid,
  input  logic [WORD_WIDTH-1:0] div_quot,
  input  logic [WORD_WIDTH-1:0] div_mod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_quot,
  output logic [WORD_WIDTH-1:0] out_mod,
  output logic [1:0]            out_err,
  output logic                  busy
);

  localparam int unsigned TMR_W  = clog2(TIMEOUT_CYCLES);
  localparam int unsigned PAIR_W = 2 * WORD_WIDTH;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [WORD_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic [WORD_WIDTH-1:0] res_quot_q, res_quot_d, res_mod_q, res_mod_d;
  logic [ERR_W-1:0]      res_err_q, res_err_d;
  logic [WORD_WIDTH-1:0] out_quot_q, out_quot_d, out_mod_q, out_mod_d;
  logic [ERR_W-1:0]      out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  div_enable_q, div_enable_d;
  logic                  busy_q, busy_d;

  logic                  fifo_pop, fifo_empty, fifo_empty_next;
  logic [PAIR_W-1:0]     fifo_head;
  logic [WORD_WIDTH-1:0] head_left, head_right;

  div_op_fifo #(
    .DATA_WIDTH (PAIR_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (in_valid),
    .push_data_i  ({in_left, in_right}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .empty_next_o (fifo_empty_next),
    .ready_o      (in_ready)
  );

  assign head_left  = fifo_head[PAIR_W-1:WORD_WIDTH];
  assign head_right = fifo_head[WORD_WIDTH-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    left_d       = left_q;
    right_d      = right_q;
    res_quot_d   = res_quot_q;
    res_mod_d    = res_mod_q;
    res_err_d    = res_err_q;
    out_quot_d   = out_quot_q;
    out_mod_d    = out_mod_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    div_enable_d = div_enable_q;
    fifo_pop     = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          left_d   = head_left;
          right_d  = head_right;
          if (head_right == '0) begin
            // Divide-by-zero never reaches the divider.
            out_quot_d         = '1;
            out_mod_d          = head_left;
            out_err_d          = '0;
            out_err_d[ERR_DBZ] = 1'b1;
            state_d            = SEQ_OUTPUT;
          end else begin
            timer_d      = '0;
            div_enable_d = 1'b1;
            state_d      = SEQ_ISSUE;
          end
        end
      end

      SEQ_ISSUE: begin
        timer_d = timer_q + TMR_W'(1);
        // A valid response wins over a coincident timeout.
        if (div_valid) begin
          res_quot_d   = div_quot;
          res_mod_d    = div_mod;
          res_err_d    = '0;
          div_enable_d = 1'b0;
          timer_d      = '0;
          state_d      = SEQ_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          res_quot_d             = '0;
          res_mod_d              = '0;
          res_err_d              = '0;
          res_err_d[ERR_TIMEOUT] = 1'b1;
          div_enable_d           = 1'b0;
          timer_d                = '0;
          state_d                = SEQ_RELEASE;
        end
      end

      SEQ_RELEASE: begin
        timer_d = timer_q + TMR_W'(1);
        if (!div_valid) begin
          out_quot_d = res_quot_q;
          out_mod_d  = res_mod_q;
          out_err_d  = res_err_q;
          timer_d    = '0;
          state_d    = SEQ_OUTPUT;
        end else if (timer_q == TMR_LAST) begin
          out_quot_d             = res_quot_q;
          out_mod_d              = res_mod_q;
          out_err_d              = res_err_q;
          out_err_d[ERR_TIMEOUT] = 1'b1;
          timer_d                = '0;
          state_d                = SEQ_OUTPUT;
        end
      end

      SEQ_OUTPUT: begin
        // out_valid rises one cycle after entry, after the data registers settle.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = SEQ_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: state_d = SEQ_IDLE;
    endcase
  end

  assign busy_d = (state_d != SEQ_IDLE) || !fifo_empty_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SEQ_IDLE;
      timer_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      res_quot_q   <= '0;
      res_mod_q    <= '0;
      res_err_q    <= '0;
      out_quot_q   <= '0;
      out_mod_q    <= '0;
      out_err_q    <= '0;
      out_valid_q  <= 1'b0;
      div_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      left_q       <= left_d;
      right_q      <= right_d;
      res_quot_q   <= res_quot_d;
      res_mod_q    <= res_mod_d;
      res_err_q    <= res_err_d;
      out_quot_q   <= out_quot_d;
      out_mod_q    <= out_mod_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      div_enable_q <= div_enable_d;
      busy_q       <= busy_d;
    end
  end

  assign div_enable   = div_enable_q;
  assign div_left_op  = left_q;
  assign div_right_op = right_q;
  assign out_valid    = out_valid_q;
  assign out_quot     = out_quot_q;
  assign out_mod      = out_mod_q;
  assign out_err      = out_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Self-checking bench for div_request_sequencer with a behavioural divider.
module tb_div_request_sequencer;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] m;
    logic [1:0] e;
  } res_t;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    int         lat;
    res_t       exp;
  } vec_t;

  logic       clk, reset_n;
  logic       in_valid, in_ready;
  logic [7:0] in_left, in_right;
  logic       div_enable, div_valid;
  logic [7:0] div_left_op, div_right_op, div_quot, div_mod;
  logic       out_valid, out_ready;
  logic [7:0] out_quot, out_mod;
  logic [1:0] out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int div_lat = 1;
  int rel_hold = 0;
  bit div_hang = 0;
  bit div_rand = 0;
  res_t exp_q[$];

  div_request_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .div_enable(div_enable), .div_left_op(div_left_op), .div_right_op(div_right_op),
    .div_valid(div_valid), .div_quot(div_quot), .div_mod(div_mod),
    .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot), .out_mod(out_mod),
    .out_err(out_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] l, input logic [7:0] r);
    res_t x;
    if (r == 8'd0) begin
      x.q = 8'hFF; x.m = l; x.e = 2'b01;
    end else begin
      x.q = l / r; x.m = l % r; x.e = 2'b00;
    end
    return x;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called and returns at posedge+1; the offered pair is accepted at the next edge.
  task automatic push(input logic [7:0] l, input logic [7:0] r, input res_t e);
    int n = 0;
    while (!in_ready && n < 300) begin step(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_ready_timeout actual=0 required=1");
    end
    in_valid = 1'b1; in_left = l; in_right = r;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Behavioural divider: answers an enable after a latency, holds valid until
  // enable drops plus rel_hold cycles.
  initial begin
    logic [7:0] dl, dr;
    int lat, n;
    div_valid = 1'b0; div_quot = 8'd0; div_mod = 8'd0;
    forever begin
      step();
      if (div_enable && !div_hang && reset_n) begin
        lat = div_rand ? int'($urandom_range(1, 10)) : div_lat;
        dl = div_left_op; dr = div_right_op;
        repeat (lat - 1) step();
        div_quot  = (dr != 8'd0) ? dl / dr : 8'd0;
        div_mod   = (dr != 8'd0) ? dl % dr : 8'd0;
        div_valid = 1'b1;
        n = 0;
        while (div_enable && n < 300) begin step(); n++; end
        repeat (rel_hold) step();
        div_valid = 1'b0;
      end
    end
  end

  // Scoreboard and stability monitor, sampled on the falling edge.
  initial begin
    logic       prev_hold, prev_en;
    logic [7:0] pq, pm, pl, pr;
    logic [1:0] pe;
    res_t       e;
    prev_hold = 1'b0; prev_en = 1'b0;
    pq = 0; pm = 0; pl = 0; pr = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 1'b0; prev_en = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_quot", 32'(out_quot), 32'(pq));
          chk("hold_mod", 32'(out_mod), 32'(pm));
          chk("hold_err", 32'(out_err), 32'(pe));
        end
        if (prev_en && div_enable) begin
          chk("op_left_stable", 32'(div_left_op), 32'(pl));
          chk("op_right_stable", 32'(div_right_op), 32'(pr));
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=%0h/%0h/%0h required=none", out_quot, out_mod, out_err);
          end else begin
            e = exp_q.pop_front();
            if (out_quot !== e.q || out_mod !== e.m || out_err !== e.e) begin
              errors++;
              $display("FAIL result actual=q%0h m%0h e%0h required=q%0h m%0h e%0h",
                       out_quot, out_mod, out_err, e.q, e.m, e.e);
            end
          end
        end
        prev_hold = out_valid && !out_ready;
        pq = out_quot; pm = out_mod; pe = out_err;
        prev_en = div_enable; pl = div_left_op; pr = div_right_op;
      end
    end
  end

  vec_t tbl[7];

  initial begin
    int n;
    logic [7:0] l, r;
    tbl[0] = '{l: 8'd255, r: 8'd1,   lat: 1, exp: '{q: 8'hFF, m: 8'h00, e: 2'b00}};
    tbl[1] = '{l: 8'd7,   r: 8'd9,   lat: 5, exp: '{q: 8'h00, m: 8'h07, e: 2'b00}};
    tbl[2] = '{l: 8'd0,   r: 8'd3,   lat: 2, exp: '{q: 8'h00, m: 8'h00, e: 2'b00}};
    tbl[3] = '{l: 8'd200, r: 8'd200, lat: 8, exp: '{q: 8'h01, m: 8'h00, e: 2'b00}};
    tbl[4] = '{l: 8'd255, r: 8'd16,  lat: 3, exp: '{q: 8'h0F, m: 8'h0F, e: 2'b00}};
    tbl[5] = '{l: 8'd0,   r: 8'd0,   lat: 1, exp: '{q: 8'hFF, m: 8'h00, e: 2'b01}};
    tbl[6] = '{l: 8'd128, r: 8'd3,   lat: 4, exp: '{q: 8'h2A, m: 8'h02, e: 2'b00}};

    reset_n = 1'b0; in_valid = 1'b0; in_left = 0; in_right = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_enable", 32'(div_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'({out_quot, out_mod, out_err}), 32'd0);
    reset_n = 1'b1;
    step();

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      div_lat = tbl[i].lat;
      push(tbl[i].l, tbl[i].r, tbl[i].exp);
      wait_empty(300);
    end

    // Basic division with a 20-cycle divider; enable one cycle after push.
    div_lat = 20;
    push(8'd100, 8'd7, '{q: 8'd14, m: 8'd2, e: 2'b00});
    chk("t1_enable_after_push", 32'(div_enable), 32'd0);
    step();
    chk("t1_enable_after_pop", 32'(div_enable), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_empty(300);

    // Divide-by-zero: no enable, out_valid two cycles after the push.
    push(8'd55, 8'd0, '{q: 8'hFF, m: 8'd55, e: 2'b01});
    chk("t2_valid_n0", 32'({out_valid, div_enable}), 32'd0);
    step();
    chk("t2_valid_n1", 32'({out_valid, div_enable}), 32'd0);
    step();
    chk("t2_valid_n2", 32'({out_valid, div_enable}), 32'b10);
    wait_empty(50);

    // Back-to-back pushes against a slow divider fill the FIFO.
    div_lat = 30;
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready_before_push", 32'(in_ready), 32'd1);
      l = 8'(10 * i + 50); r = 8'(i + 2);
      push(l, r, model(l, r));
    end
    chk("t3_ready_when_full", 32'(in_ready), 32'd0);
    chk("t3_busy_when_full", 32'(busy), 32'd1);
    wait_empty(1000);

    // Hung divider: enable held exactly TIMEOUT_CYCLES cycles, then next pair works.
    div_hang = 1'b1;
    push(8'd123, 8'd5, '{q: 8'd0, m: 8'd0, e: 2'b10});
    step();
    n = 0;
    while (div_enable && n < 200) begin n++; step(); end
    chk("t4_issue_cycles", 32'(n), 32'd64);
    wait_empty(50);
    div_hang = 1'b0; div_lat = 3;
    push(8'd9, 8'd2, '{q: 8'd4, m: 8'd1, e: 2'b00});
    wait_empty(100);

    // Consumer stall: result held, no new issue, FIFO still accepts.
    out_ready = 1'b0;
    push(8'd90, 8'd9, '{q: 8'd10, m: 8'd0, e: 2'b00});
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("t5_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        chk("t5_ready_during_hold", 32'(in_ready), 32'd1);
        push(8'd20, 8'd3, '{q: 8'd6, m: 8'd2, e: 2'b00});
      end else begin
        step();
      end
      chk("t5_no_enable", 32'(div_enable), 32'd0);
      chk("t5_quot_held", 32'(out_quot), 32'd10);
    end
    out_ready = 1'b1;
    wait_empty(100);

    // Divider holds valid too long after release: timeout flag, data kept.
    div_lat = 2; rel_hold = 70;
    push(8'd50, 8'd6, '{q: 8'd8, m: 8'd2, e: 2'b10});
    wait_empty(200);
    repeat (20) step();
    rel_hold = 0;

    // Reset in the middle of ISSUE discards everything.
    div_hang = 1'b1;
    push(8'd11, 8'd3, model(8'd11, 8'd3));
    push(8'd12, 8'd3, model(8'd12, 8'd3));
    push(8'd13, 8'd3, model(8'd13, 8'd3));
    repeat (5) step();
    chk("t6_enable_before_reset", 32'(div_enable), 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    step();
    chk("t6_enable", 32'(div_enable), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    div_hang = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_idle_after", 32'({div_enable, busy, out_valid}), 32'd0);
    end
    div_lat = 2;
    push(8'd9, 8'd2, '{q: 8'd4, m: 8'd1, e: 2'b00});
    wait_empty(100);

    // Randomised traffic against the reference model.
    div_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_ready && $urandom_range(0, 2) == 0) begin
        l = 8'($urandom);
        r = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        in_valid = 1'b1; in_left = l; in_right = r;
        exp_q.push_back(model(l, r));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_empty(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
